control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired multi-cycle control unit for the 32-bit bus datapath. Fetches via PC/MAR/MDR/IR, decodes IR[31:27],
//  and drives every register enable, bus-out select, the ALU opcode and memory strobes, one micro-step (Tn) per clk.
//  Sits beside the datapath; the datapath's IR, CON FF and bus-driver inputs connect here one-to-one.
// PARAMETERS
//  NREG    16   general registers (one-hot width of reg_in/reg_out)
//  OPW     5    opcode / ALU-op width
//  ADD_OP  5'd3 ALU op forced for address and branch-target arithmetic
// PORTS
//  clk        in   1     rising-edge clock
//  clr        in   1     synchronous active-high reset
//  ir         in   32    IR contents: op=[31:27] ra=[26:23] rb=[22:19] rc=[18:15] C=[18:0]
//  con_ff     in   1     branch condition flag, sampled in T5 of br
//  stop       in   1     level; finish current instruction, then halt
//  reg_in     out  NREG  one-hot R0..R15 enable
//  reg_out    out  NREG  one-hot R0..R15 bus drive
//  PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable  out 1 each
//  PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout  out 1 each  bus drivers (Cout = sign-extended C)
//  IncPC      out  1     PC-increment request to ALU/PC mux
//  Read, Write out 1     memory strobes
//  opcode     out  OPW   ALU operation
//  run        out  1     1 while executing; 0 in RESET/HALT
// BEHAVIOUR
//  Reset: clr high at an edge -> state RESET, every output 0 next cycle, regardless of current step (mid-instruction
//   abort, no partial writes after that edge). RESET -> T0 on the first edge with clr low; run=1 from T0.
//  Fetch (all instrs): T0 PCout,MAR_enable,IncPC,Z_enable; T1 ZLowout,PC_enable,Read,MDR_enable; T2 MDRout,IR_enable.
//  Execute (op decoded from ir in T3; ir stable from T3 to instruction end):
//   ALU reg (add 3,sub 4,shr 5,shl 6,ror 7,rol 8,and 9,or 10,neg 16,not 17): T3 Rb out,Y_enable;
//     T4 Rc out (Rb for neg/not),opcode=op,Z_enable; T5 ZLowout,Ra in -> T0.
//   ALU imm (addi 11,andi 12,ori 13): as ALU reg but T4 drives Cout; op mapped to add/and/or.
//   mul 14, div 15: T3 Ra out,Y_enable; T4 Rb out,opcode,Z_enable; T5 ZLowout,LO_enable; T6 ZHighout,HI_enable.
//   ld 0: T3 Rb out,Y_enable; T4 Cout,ADD_OP,Z_enable; T5 ZLowout,MAR_enable; T6 Read,MDR_enable; T7 MDRout,Ra in.
//   st 2: T3-T5 as ld; T6 Ra out,MDR_enable (Read=0); T7 Write.
//   br 18: T3 Ra out (CON FF loads); T4 PCout,Y_enable; T5 Cout,ADD_OP,Z_enable; T6 ZLowout,PC_enable iff con_ff.
//   jr 19: T3 Ra out,PC_enable.  mfhi 23 / mflo 24: T3 HIout/LOout,Ra in.
//   nop 25 and any undefined op: T3 idle -> T0.  halt 26: -> HALT.
//  HALT: all outputs 0, run=0, held until clr. stop sampled only at last step of an instruction; if high -> HALT.
//  Invariants: at most one bus driver (reg_out bits + PCout..Cout) asserted per cycle; at most one reg_in bit set;
//   Read and Write never both high; opcode=0 whenever Z_enable=0.
//  Latency from T0: alu 6, mul/div 7, ld/st 8, br 7, jr/mfhi/mflo/nop 4 cycles. Step counter saturates never;
//   each class ends with an explicit return to T0.
// STRUCTURE
//  Shared package/include ctrl_defs.vh: opcode localparams (above), step encodings T0..T7, RESET, HALT, field
//   bit positions, ADD_OP.
//  Sub-module reg_select: ra/rb/rc + gra/grb/grc + rin/rout -> one-hot reg_in/reg_out (4-to-16 decode).
//  Top: state register + step counter, combinational output decode per (class, step).
// TESTING
//  1 clr high 2 cycles, release -> all outputs 0 during clr, run=0; T0 signals one cycle after release.
//  2 ir=add r1,r2,r3 -> T3 reg_out=0x0004,Y_enable; T4 reg_out=0x0008,opcode=3; T5 ZLowout,reg_in=0x0002; T0 next.
//  3 ir=ld r4,0x10(r5) -> T4 Cout,opcode=3; T6 Read&MDR_enable; T7 reg_in=0x0010; 8 cycles total.
//  4 ir=br r6,+8 with con_ff=0 then =1 -> PC_enable low/high in T6 respectively.
//  5 clr asserted in T4 of mul -> no LO/HI enable ever, RESET then T0; stop high during div -> T6 completes, HALT, run=0.
//  6 Random 1000 instrs incl. undefined ops -> bus one-driver, one-reg_in, Read/Write exclusion assertions never fire.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcodes, IR field positions, sequencer steps and instruction classes
package control_sequencer_pkg;
  localparam int NREG = 16;
  localparam int RW = $clog2(NREG);
  localparam int OPW = 5;
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam logic [OPW-1:0] OP_LD = 5'd0, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4, OP_SHR = 5'd5,
    OP_SHL = 5'd6, OP_ROR = 5'd7, OP_ROL = 5'd8, OP_AND = 5'd9, OP_OR = 5'd10, OP_ADDI = 5'd11,
    OP_ANDI = 5'd12, OP_ORI = 5'd13, OP_MUL = 5'd14, OP_DIV = 5'd15, OP_NEG = 5'd16, OP_NOT = 5'd17,
    OP_BR = 5'd18, OP_JR = 5'd19, OP_MFHI = 5'd23, OP_MFLO = 5'd24, OP_NOP = 5'd25, OP_HALT = 5'd26;
  localparam logic [OPW-1:0] ADD_OP = OP_ADD;
  typedef enum logic [3:0] {S_RESET, S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7} state_t;
  typedef enum logic [3:0] {C_NOP, C_ALU, C_IMM, C_MUL, C_LD, C_ST, C_BR, C_JR, C_MFHI, C_MFLO, C_HALT} cls_t;
  function automatic cls_t op_class(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR, OP_NEG, OP_NOT: return C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: return C_IMM;
      OP_MUL, OP_DIV: return C_MUL;
      OP_LD: return C_LD;
      OP_ST: return C_ST;
      OP_BR: return C_BR;
      OP_JR: return C_JR;
      OP_MFHI: return C_MFHI;
      OP_MFLO: return C_MFLO;
      OP_HALT: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction
  function automatic state_t last_step(input cls_t c);
    case (c)
      C_ALU, C_IMM: return S_T5;
      C_MUL, C_BR: return S_T6;
      C_LD, C_ST: return S_T7;
      default: return S_T3;
    endcase
  endfunction
  function automatic logic [OPW-1:0] alu_code(input logic [OPW-1:0] op);
    return op == OP_ADDI ? OP_ADD : op == OP_ANDI ? OP_AND : op == OP_ORI ? OP_OR : op;
  endfunction
endpackage

// File: rtl/control_sequencer_reg_select.sv
// control_sequencer_reg_select: picks ra/rb/rc and decodes it onto one-hot register in/out enables
module control_sequencer_reg_select
  import control_sequencer_pkg::*;
(
  input  logic [RW-1:0]   ra,
  input  logic [RW-1:0]   rb,
  input  logic [RW-1:0]   rc,
  input  logic            gra,
  input  logic            grb,
  input  logic            grc,
  input  logic            rin,
  input  logic            rout,
  output logic [NREG-1:0] reg_in,
  output logic [NREG-1:0] reg_out
);
  logic [RW-1:0] sel;
  logic [NREG-1:0] dec;
  assign sel = gra ? ra : grb ? rb : grc ? rc : '0;
  assign dec = (gra | grb | grc) ? NREG'(1) << sel : '0;
  assign reg_in = rin ? dec : '0;
  assign reg_out = rout ? dec : '0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit, one micro-step per clock
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic [NREG-1:0] reg_in,
  output logic [NREG-1:0] reg_out,
  output logic            PC_enable,
  output logic            IR_enable,
  output logic            MAR_enable,
  output logic            MDR_enable,
  output logic            Y_enable,
  output logic            Z_enable,
  output logic            HI_enable,
  output logic            LO_enable,
  output logic            PCout,
  output logic            ZHighout,
  output logic            ZLowout,
  output logic            HIout,
  output logic            LOout,
  output logic            MDRout,
  output logic            Cout,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic [OPW-1:0]  opcode,
  output logic            run
);
  state_t state, nxt;
  cls_t cls;
  logic [OPW-1:0] op;
  logic gra, grb, grc, rin, rout, unused_c;
  assign op = ir[OP_LSB +: OPW];
  assign cls = op_class(op);
  assign run = state != S_RESET && state != S_HALT;
  assign unused_c = ^ir[RC_LSB-1:0];
  always_ff @(posedge clk) state <= clr ? S_RESET : nxt;
  always_comb begin
    {PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable} = '0;
    {PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout, IncPC, Read, Write} = '0;
    {opcode, gra, grb, grc, rin, rout} = '0;
    case (state)
      S_RESET: nxt = S_T0;
      S_HALT: nxt = S_HALT;
      S_T0: begin
        {PCout, MAR_enable, IncPC, Z_enable} = '1;
        nxt = S_T1;
      end
      S_T1: begin
        {ZLowout, PC_enable, Read, MDR_enable} = '1;
        nxt = S_T2;
      end
      S_T2: begin
        {MDRout, IR_enable} = '1;
        nxt = S_T3;
      end
      default: begin
        // stop is honoured only at an instruction boundary
        nxt = cls == C_HALT ? S_HALT : state == last_step(cls) ? (stop ? S_HALT : S_T0) : state_t'(state + 4'd1);
        case (state)
          S_T3: begin
            Y_enable = cls inside {C_ALU, C_IMM, C_MUL, C_LD, C_ST};
            rout = cls inside {C_ALU, C_IMM, C_MUL, C_LD, C_ST, C_BR, C_JR};
            grb = cls inside {C_ALU, C_IMM, C_LD, C_ST};
            gra = cls inside {C_MUL, C_BR, C_JR, C_MFHI, C_MFLO};
            PC_enable = cls == C_JR;
            HIout = cls == C_MFHI;
            LOout = cls == C_MFLO;
            rin = cls inside {C_MFHI, C_MFLO};
          end
          S_T4: begin
            Z_enable = cls inside {C_ALU, C_IMM, C_MUL, C_LD, C_ST};
            opcode = cls inside {C_ALU, C_IMM, C_MUL} ? alu_code(op) : cls inside {C_LD, C_ST} ? ADD_OP : '0;
            Cout = cls inside {C_IMM, C_LD, C_ST};
            rout = cls inside {C_ALU, C_MUL};
            grc = cls == C_ALU && !(op inside {OP_NEG, OP_NOT});
            grb = cls == C_MUL || (cls == C_ALU && op inside {OP_NEG, OP_NOT});
            PCout = cls == C_BR;
            Y_enable = cls == C_BR;
          end
          S_T5: begin
            ZLowout = cls inside {C_ALU, C_IMM, C_MUL, C_LD, C_ST};
            gra = cls inside {C_ALU, C_IMM};
            rin = cls inside {C_ALU, C_IMM};
            LO_enable = cls == C_MUL;
            MAR_enable = cls inside {C_LD, C_ST};
            Cout = cls == C_BR;
            Z_enable = cls == C_BR;
            opcode = cls == C_BR ? ADD_OP : '0;
          end
          S_T6: begin
            ZHighout = cls == C_MUL;
            HI_enable = cls == C_MUL;
            Read = cls == C_LD;
            MDR_enable = cls inside {C_LD, C_ST};
            gra = cls == C_ST;
            rout = cls == C_ST;
            ZLowout = cls == C_BR;
            PC_enable = cls == C_BR && con_ff;
          end
          S_T7: begin
            MDRout = cls == C_LD;
            gra = cls == C_LD;
            rin = cls == C_LD;
            Write = cls == C_ST;
          end
          default: ;
        endcase
      end
    endcase
  end
  control_sequencer_reg_select u_sel (
    .ra(ir[RA_LSB +: RW]),
    .rb(ir[RB_LSB +: RW]),
    .rc(ir[RC_LSB +: RW]),
    .gra(gra),
    .grb(grb),
    .grc(grc),
    .rin(rin),
    .rout(rout),
    .reg_in(reg_in),
    .reg_out(reg_out)
  );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: reference model queues each expected control word; every cycle is compared
module tb_control_sequencer;
  logic clk = 0, clr = 1, con_ff = 0, stop = 0;
  logic [31:0] ir = '0;
  logic [15:0] reg_in, reg_out;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable;
  logic PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout, IncPC, Read, Write, run;
  logic [4:0] opcode;
  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pc_en, ir_en, mar_en, mdr_en, y_en, z_en, hi_en, lo_en;
    logic pcout, zhout, zlout, hiout, loout, mdrout, cout, incpc, rd, wr;
    logic [4:0] opc;
    logic run;
  } vec_t;
  vec_t q[$];
  vec_t trace[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .reg_in(reg_in), .reg_out(reg_out),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .IncPC(IncPC), .Read(Read), .Write(Write),
    .opcode(opcode), .run(run)
  );
  function automatic vec_t observed();
    return {reg_in, reg_out, PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable,
            LO_enable, PCout, ZHighout, ZLowout, HIout, LOout, MDRout, Cout, IncPC, Read, Write, opcode, run};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'(1) << r;
  endfunction
  function automatic vec_t base();
    vec_t v = '0;
    v.run = 1;
    return v;
  endfunction
  task automatic push_model(input logic [31:0] i, input logic cf);
    logic [4:0] op = i[31:27];
    logic [3:0] ra = i[26:23], rb = i[22:19], rc = i[18:15];
    vec_t v;
    v = base(); v.pcout = 1; v.mar_en = 1; v.incpc = 1; v.z_en = 1; q.push_back(v);
    v = base(); v.zlout = 1; v.pc_en = 1; v.rd = 1; v.mdr_en = 1; q.push_back(v);
    v = base(); v.mdrout = 1; v.ir_en = 1; q.push_back(v);
    case (op)
      3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 16, 17: begin
        v = base(); v.rout = oh(rb); v.y_en = 1; q.push_back(v);
        v = base(); v.z_en = 1;
        v.opc = op == 11 ? 5'd3 : op == 12 ? 5'd9 : op == 13 ? 5'd10 : op;
        if (op >= 11 && op <= 13) v.cout = 1; else v.rout = oh(op >= 16 ? rb : rc);
        q.push_back(v);
        v = base(); v.zlout = 1; v.rin = oh(ra); q.push_back(v);
      end
      14, 15: begin
        v = base(); v.rout = oh(ra); v.y_en = 1; q.push_back(v);
        v = base(); v.rout = oh(rb); v.opc = op; v.z_en = 1; q.push_back(v);
        v = base(); v.zlout = 1; v.lo_en = 1; q.push_back(v);
        v = base(); v.zhout = 1; v.hi_en = 1; q.push_back(v);
      end
      0, 2: begin
        v = base(); v.rout = oh(rb); v.y_en = 1; q.push_back(v);
        v = base(); v.cout = 1; v.opc = 5'd3; v.z_en = 1; q.push_back(v);
        v = base(); v.zlout = 1; v.mar_en = 1; q.push_back(v);
        if (op == 0) begin
          v = base(); v.rd = 1; v.mdr_en = 1; q.push_back(v);
          v = base(); v.mdrout = 1; v.rin = oh(ra); q.push_back(v);
        end else begin
          v = base(); v.rout = oh(ra); v.mdr_en = 1; q.push_back(v);
          v = base(); v.wr = 1; q.push_back(v);
        end
      end
      18: begin
        v = base(); v.rout = oh(ra); q.push_back(v);
        v = base(); v.pcout = 1; v.y_en = 1; q.push_back(v);
        v = base(); v.cout = 1; v.opc = 5'd3; v.z_en = 1; q.push_back(v);
        v = base(); v.zlout = 1; v.pc_en = cf; q.push_back(v);
      end
      19: begin v = base(); v.rout = oh(ra); v.pc_en = 1; q.push_back(v); end
      23: begin v = base(); v.hiout = 1; v.rin = oh(ra); q.push_back(v); end
      24: begin v = base(); v.loout = 1; v.rin = oh(ra); q.push_back(v); end
      default: q.push_back(base());
    endcase
  endtask
  task automatic invariants(input vec_t v);
    chk("one_driver", $countones({v.rout, v.pcout, v.zhout, v.zlout, v.hiout, v.loout, v.mdrout, v.cout}) <= 1, 1);
    chk("one_reg_in", $countones(v.rin) <= 1, 1);
    chk("rd_wr_excl", v.rd & v.wr, 0);
    chk("opc_idle", v.z_en ? 5'd0 : v.opc, 0);
  endtask
  task automatic run_instr(input logic [31:0] i, input logic cf, input logic st, input int abort_at);
    vec_t got, exp;
    int n = 0;
    @(posedge clk) #1;
    ir = i; con_ff = cf; stop = st;
    push_model(i, cf);
    trace.delete();
    while (q.size() > 0) begin
      @(negedge clk);
      got = observed();
      exp = q.pop_front();
      trace.push_back(got);
      chk($sformatf("op%0d_t%0d", i[31:27], n), got, exp);
      invariants(got);
      if (n == abort_at) begin
        q.delete();
        clr = 1;
        @(negedge clk);
        chk("abort_reset", observed(), '0);
        clr = 0;
      end
      n++;
    end
    if (abort_at < 0 && (st || i[31:27] == 5'd26)) begin
      repeat (2) begin
        @(negedge clk);
        chk("halt_hold", observed(), '0);
      end
      stop = 0;
      clr = 1;
      @(negedge clk);
      chk("halt_clr", observed(), '0);
      clr = 0;
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end
  initial begin
    repeat (2) begin
      @(negedge clk);
      chk("reset_out", observed(), '0);
      chk("reset_run", run, 0);
    end
    clr = 0;
    run_instr({5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0, -1);
    chk("add_len", trace.size(), 6);
    chk("add_t3_rout", trace[3].rout, 16'h0004);
    chk("add_t3_y", trace[3].y_en, 1);
    chk("add_t4_rout", trace[4].rout, 16'h0008);
    chk("add_t4_opc", trace[4].opc, 3);
    chk("add_t5_rin", trace[5].rin, 16'h0002);
    chk("add_t5_zlo", trace[5].zlout, 1);
    run_instr({5'd0, 4'd4, 4'd5, 19'h10}, 0, 0, -1);
    chk("ld_len", trace.size(), 8);
    chk("ld_t4_cout", trace[4].cout, 1);
    chk("ld_t4_opc", trace[4].opc, 3);
    chk("ld_t6_rd", trace[6].rd & trace[6].mdr_en, 1);
    chk("ld_t7_rin", trace[7].rin, 16'h0010);
    run_instr({5'd18, 4'd6, 4'd0, 19'd8}, 0, 0, -1);
    chk("br0_len", trace.size(), 7);
    chk("br0_pc_en", trace[6].pc_en, 0);
    run_instr({5'd18, 4'd6, 4'd0, 19'd8}, 1, 0, -1);
    chk("br1_pc_en", trace[6].pc_en, 1);
    run_instr({5'd14, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0, 4);
    chk("mul_abort_len", trace.size(), 5);
    chk("mul_abort_t4_z", trace[4].z_en, 1);
    run_instr({5'd15, 4'd7, 4'd8, 4'd0, 15'd0}, 0, 1, -1);
    chk("div_stop_len", trace.size(), 7);
    chk("div_stop_t6_hi", trace[6].hi_en, 1);
    run_instr({5'd19, 4'd9, 23'd0}, 0, 0, -1);
    chk("jr_len", trace.size(), 4);
    run_instr({5'd26, 27'd0}, 0, 0, -1);
    for (int k = 0; k < 1000; k++)
      run_instr($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
